// File: rtl/ecc_serial_frame_rx.sv
// Multi-lane bit-serial frame receiver: optional 2-bit length header, then N bits per lane MSB-first
// collected into zero-extended MAX_BITS registers, with done/busy/restart status.
module ecc_serial_frame_rx #(
  parameter int MAX_BITS   = 256,
  parameter int LANES      = 6,
  parameter int HAS_HEADER = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      i_mode,
  input  logic [1:0]                i_len_sel,
  input  logic [LANES-1:0]          i_data,
  output logic [LANES*MAX_BITS-1:0] o_data,
  output logic [1:0]                o_len_sel,
  output logic                      o_done,
  output logic                      o_busy,
  output logic                      o_restart_err
);

  localparam int CW = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {IDLE, HDR1, HDR0, SHIFT} state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    len_reg, len_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
  logic          clr, shift_en;

  function automatic logic [CW-1:0] len_decode(input logic [1:0] code);
    case (code)
      2'd0:    return CW'(MAX_BITS / 8);
      2'd1:    return CW'(MAX_BITS / 4);
      2'd2:    return CW'(MAX_BITS / 2);
      default: return CW'(MAX_BITS);
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      len_reg   <= '0;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  // A start strobe wins over every state, so a restart begins on the same edge as a fresh frame.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    clr        = 1'b0;
    shift_en   = 1'b0;
    if (i_valid) begin
      clr      = 1'b1;
      err_next = (state_reg != IDLE);
      if (HAS_HEADER != 0) begin
        state_next = HDR1;
      end else begin
        len_next   = i_len_sel;
        cnt_next   = len_decode(i_len_sel);
        state_next = SHIFT;
      end
    end else begin
      case (state_reg)
        HDR1: begin
          len_next   = {i_mode, len_reg[0]};
          state_next = HDR0;
        end
        HDR0: begin
          len_next   = {len_reg[1], i_mode};
          cnt_next   = len_decode({len_reg[1], i_mode});
          state_next = SHIFT;
        end
        SHIFT: begin
          shift_en = 1'b1;
          cnt_next = cnt_reg - CW'(1);
          if (cnt_reg == CW'(1)) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Clearing at frame start is what zero-extends short operands.
  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      logic [MAX_BITS-1:0] lane_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          lane_reg <= '0;
        else if (clr)      lane_reg <= '0;
        else if (shift_en) lane_reg <= {lane_reg[MAX_BITS-2:0], i_data[gi]};
      end
      assign o_data[gi*MAX_BITS +: MAX_BITS] = lane_reg;
    end
  endgenerate

  assign o_len_sel     = len_reg;
  assign o_done        = done_reg;
  assign o_busy        = (state_reg != IDLE);
  assign o_restart_err = err_reg;

endmodule

// File: tb/tb_ecc_serial_frame_rx.sv
// Bench for ecc_serial_frame_rx: a header-mode (6-lane) and a no-header (2-lane) instance driven
// with directed and random frames, compared against an operand/length model.
module tb_ecc_serial_frame_rx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic              mp_valid = 1'b0, mp_mode = 1'b0;
  logic [1:0]        mp_len_in = 2'b00;
  logic [5:0]        mp_data = '0;
  logic [6*256-1:0]  mp_out;
  logic [1:0]        mp_len;
  logic              mp_done, mp_busy, mp_err;

  logic              np_valid = 1'b0, np_mode = 1'b0;
  logic [1:0]        np_len_in = 2'b00;
  logic [1:0]        np_data = '0;
  logic [2*256-1:0]  np_out;
  logic [1:0]        np_len;
  logic              np_done, np_busy, np_err;

  ecc_serial_frame_rx #(.MAX_BITS(256), .LANES(6), .HAS_HEADER(1)) u_mp (
    .clk(clk), .rst(rst), .i_valid(mp_valid), .i_mode(mp_mode), .i_len_sel(mp_len_in),
    .i_data(mp_data), .o_data(mp_out), .o_len_sel(mp_len), .o_done(mp_done),
    .o_busy(mp_busy), .o_restart_err(mp_err));

  ecc_serial_frame_rx #(.MAX_BITS(256), .LANES(2), .HAS_HEADER(0)) u_np (
    .clk(clk), .rst(rst), .i_valid(np_valid), .i_mode(np_mode), .i_len_sel(np_len_in),
    .i_data(np_data), .o_data(np_out), .o_len_sel(np_len), .o_done(np_done),
    .o_busy(np_busy), .o_restart_err(np_err));

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Operand length in bits for a length code: 32, 64, 128, 256.
  function automatic int n_of(input logic [1:0] c);
    return 32 << c;
  endfunction

  // Only the low n bits of the operand are transmitted; everything above must read as zero.
  function automatic logic [255:0] expect_lane(input logic [255:0] v, input int n);
    if (n >= 256) return v;
    return v & ((256'd1 << n) - 256'd1);
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic mp_start(input logic [1:0] c, input bit expect_err, input bit valid_pre);
    if (!valid_pre) begin
      @(negedge clk);
      mp_valid = 1'b1;
      mp_mode  = 1'bx;
    end
    @(negedge clk);
    mp_valid = 1'b0;
    check("mp_busy_hdr", mp_busy, 1);
    check("mp_err_start", mp_err, expect_err);
    check("mp_done_start", mp_done, 0);
    for (int l = 0; l < 6; l++) check($sformatf("mp_clear%0d", l), mp_out[l*256 +: 256], 0);
    mp_mode = c[1];
    mp_data = 6'($urandom);
    @(negedge clk);
    check("mp_err_hdr0", mp_err, 0);
    mp_mode = c[0];
  endtask

  task automatic mp_bits(input logic [5:0][255:0] v, input int n, input int k);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      check("mp_busy_shift", mp_busy, 1);
      check("mp_done_shift", mp_done, 0);
      check("mp_err_shift", mp_err, 0);
      mp_mode = 1'bx;
      for (int l = 0; l < 6; l++) mp_data[l] = v[l][n-1-i];
    end
  endtask

  task automatic mp_finish(input logic [1:0] c, input logic [5:0][255:0] v, input bit chain);
    @(negedge clk);
    check("mp_done", mp_done, 1);
    check("mp_busy_done", mp_busy, 0);
    check("mp_err_done", mp_err, 0);
    check("mp_len", mp_len, c);
    for (int l = 0; l < 6; l++)
      check($sformatf("mp_lane%0d", l), mp_out[l*256 +: 256], expect_lane(v[l], n_of(c)));
    mp_data = 6'($urandom);
    if (chain) begin
      mp_valid = 1'b1;
      mp_mode  = 1'bx;
    end else begin
      @(negedge clk);
      check("mp_done_pulse", mp_done, 0);
      check("mp_busy_idle", mp_busy, 0);
      check("mp_hold0", mp_out[255:0], expect_lane(v[0], n_of(c)));
    end
  endtask

  task automatic np_frame(input logic [1:0] sel, input logic [1:0][255:0] v);
    int n;
    n = n_of(sel);
    @(negedge clk);
    np_valid  = 1'b1;
    np_len_in = sel;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      np_valid  = 1'b0;
      np_len_in = 2'($urandom);
      check("np_busy", np_busy, 1);
      check("np_done_shift", np_done, 0);
      if (i == 0) check("np_clear", np_out[255:0] | np_out[511:256], 0);
      for (int l = 0; l < 2; l++) np_data[l] = v[l][n-1-i];
    end
    @(negedge clk);
    check("np_done", np_done, 1);
    check("np_busy_done", np_busy, 0);
    check("np_err", np_err, 0);
    check("np_len", np_len, sel);
    for (int l = 0; l < 2; l++)
      check($sformatf("np_lane%0d", l), np_out[l*256 +: 256], expect_lane(v[l], n));
    np_data = 2'($urandom);
    @(negedge clk);
    check("np_done_pulse", np_done, 0);
  endtask

  initial begin
    logic [5:0][255:0] v, v2;
    logic [1:0][255:0] w;
    logic [1:0]        c;
    bit                pre;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_mp_data", mp_out[255:0] | mp_out[1535:1280], 0);
    check("rst_mp_len", mp_len, 0);
    check("rst_mp_flags", {mp_done, mp_busy, mp_err}, 0);
    check("rst_np_data", np_out[255:0] | np_out[511:256], 0);
    check("rst_np_flags", {np_len, np_done, np_busy, np_err}, 0);
    rst = 1'b1;

    // Header 00, lane0 = DEADBEEF
    v = '0;
    v[0] = 256'hDEADBEEF;
    mp_start(2'b00, 0, 0);
    mp_bits(v, 32, 32);
    mp_finish(2'b00, v, 0);

    // Header 11, lane3 = 8000...0001 full width
    for (int l = 0; l < 6; l++) v[l] = rnd256();
    v[3] = {1'b1, 254'b0, 1'b1};
    mp_start(2'b11, 0, 0);
    mp_bits(v, 256, 256);
    mp_finish(2'b11, v, 0);

    // Random back-to-back frames, each new i_valid in the previous done cycle
    pre = 1'b0;
    for (int f = 0; f < 4; f++) begin
      c = 2'($urandom);
      for (int l = 0; l < 6; l++) v[l] = rnd256();
      mp_start(c, 0, pre);
      mp_bits(v, n_of(c), n_of(c));
      mp_finish(c, v, f < 3);
      pre = (f < 3);
    end

    // Restart after 40 bits of a 128-bit frame, then a full 32-bit frame
    for (int l = 0; l < 6; l++) v[l] = rnd256();
    mp_start(2'b10, 0, 0);
    mp_bits(v, 128, 40);
    v2 = '0;
    v2[0] = 256'h12345678;
    mp_start(2'b00, 1, 0);
    mp_bits(v2, 32, 32);
    mp_finish(2'b00, v2, 0);

    // Reset in the middle of SHIFT
    for (int l = 0; l < 6; l++) v[l] = rnd256();
    mp_start(2'b01, 0, 0);
    mp_bits(v, 64, 20);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mrst_data", mp_out[255:0] | mp_out[1535:1280], 0);
    check("mrst_len", mp_len, 0);
    check("mrst_flags", {mp_done, mp_busy, mp_err}, 0);
    @(negedge clk);
    @(negedge clk);
    check("mrst_hold", {mp_len, mp_done, mp_busy, mp_err}, 0);
    rst = 1'b1;
    c = 2'($urandom);
    for (int l = 0; l < 6; l++) v[l] = rnd256();
    mp_start(c, 0, 0);
    mp_bits(v, n_of(c), n_of(c));
    mp_finish(c, v, 0);

    // No-header channel: directed 64-bit pair, then random lengths
    w[0] = 256'h0123456789ABCDEF;
    w[1] = 256'hFEDCBA9876543210;
    np_frame(2'b01, w);
    for (int f = 0; f < 3; f++) begin
      w[0] = rnd256();
      w[1] = rnd256();
      np_frame(2'($urandom), w);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
